// File: rtl/panel_entry.sv
// Front-panel entry unit: debounced keys, switch capture,
// hand-loading write handshake and single-step strobe.

// One debounced key: 2-FF synchronizer plus stability counter.
// press_o pulses for one cycle on an accepted 1->0 flip.
module panel_debounce #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples disagreeing with the accepted level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = ~level_q;
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, accepted level, counter and press register.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

module panel_entry #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       entry_en,
    input  logic [7:0] SW,
    input  logic       KEY_addr,
    input  logic       KEY_data,
    input  logic       KEY_step,
    input  logic       wr_ack,
    output logic [7:0] entry_addr,
    output logic [7:0] entry_data,
    output logic       wr_req,
    output logic       step_pulse,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] addr_q;
    logic [7:0] addr_d;
    logic [7:0] data_q;
    logic [7:0] data_d;
    logic       wr_req_q;
    logic       wr_req_d;

    logic addr_press;
    logic data_press;
    logic step_press;

    panel_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_addr (
        .clk    (clk),
        .clr    (clr),
        .key_n_i(KEY_addr),
        .press_o(addr_press)
    );

    panel_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_data (
        .clk    (clk),
        .clr    (clr),
        .key_n_i(KEY_data),
        .press_o(data_press)
    );

    panel_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_step (
        .clk    (clk),
        .clr    (clr),
        .key_n_i(KEY_step),
        .press_o(step_press)
    );

    // Entry FSM: address latch, data capture, write handshake.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_req_d = wr_req_q;
        unique case (state_q)
            ST_IDLE: begin
                if (entry_en && addr_press) begin
                    addr_d  = SW;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!entry_en) begin
                    state_d = ST_IDLE;
                end else if (addr_press) begin
                    addr_d = SW;
                end else if (data_press) begin
                    data_d   = SW;
                    wr_req_d = 1'b1;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    addr_d   = addr_q + 8'd1;
                    state_d  = entry_en ? ST_ARMED : ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_req_d = 1'b0;
            end
        endcase
    end

    // FSM state and entry registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            wr_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_req_q <= wr_req_d;
        end
    end

    assign entry_addr = addr_q;
    assign entry_data = data_q;
    assign wr_req     = wr_req_q;
    assign busy       = (state_q == ST_WRITE);
    assign step_pulse = step_press & ~entry_en;

endmodule

// File: tb/tb_panel_entry.sv
// Bench for panel_entry: scenario tasks plus randomized traffic,
// all checked against a behavioural model of the panel.

module tb_panel_entry;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       entry_en = 1'b0;
    logic [7:0] SW = 8'h00;
    logic       KEY_addr = 1'b1;
    logic       KEY_data = 1'b1;
    logic       KEY_step = 1'b1;
    logic       wr_ack = 1'b0;
    logic [7:0] entry_addr;
    logic [7:0] entry_data;
    logic       wr_req;
    logic       step_pulse;
    logic       busy;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    panel_entry #(
        .DEB_CYCLES(DEB),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .entry_en  (entry_en),
        .SW        (SW),
        .KEY_addr  (KEY_addr),
        .KEY_data  (KEY_data),
        .KEY_step  (KEY_step),
        .wr_ack    (wr_ack),
        .entry_addr(entry_addr),
        .entry_data(entry_data),
        .wr_req    (wr_req),
        .step_pulse(step_pulse),
        .busy      (busy)
    );

    // Reference model: each key's raw samples reach the debouncer two
    // edges late; a level change needs DEB consecutive differing samples;
    // an accepted press is acted on one edge after it is recognised.
    bit       raw_hist[3][$];
    bit       m_lvl[3] = '{1'b1, 1'b1, 1'b1};
    int       m_run[3] = '{0, 0, 0};
    bit       m_prs[3] = '{1'b0, 1'b0, 1'b0};
    bit [7:0] m_addr = 8'h00;
    bit [7:0] m_data = 8'h00;
    bit       m_wr = 1'b0;
    bit       m_armed = 1'b0;
    bit       m_writing = 1'b0;

    always @(posedge clk) begin : model
        bit raw[3];
        bit smp;
        raw = '{KEY_addr, KEY_data, KEY_step};
        if (clr) begin
            for (int k = 0; k < 3; k++) begin
                raw_hist[k].delete();
                m_lvl[k] = 1'b1;
                m_run[k] = 0;
                m_prs[k] = 1'b0;
            end
            m_addr = 8'h00;
            m_data = 8'h00;
            m_wr = 1'b0;
            m_armed = 1'b0;
            m_writing = 1'b0;
        end else begin
            if (m_writing) begin
                if (wr_ack) begin
                    m_wr = 1'b0;
                    m_addr = m_addr + 8'd1;
                    m_writing = 1'b0;
                    m_armed = entry_en;
                end
            end else if (m_armed) begin
                if (!entry_en) begin
                    m_armed = 1'b0;
                end else if (m_prs[0]) begin
                    m_addr = SW;
                end else if (m_prs[1]) begin
                    m_data = SW;
                    m_wr = 1'b1;
                    m_writing = 1'b1;
                    m_armed = 1'b0;
                end
            end else if (entry_en && m_prs[0]) begin
                m_addr = SW;
                m_armed = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                smp = 1'b1;
                if (raw_hist[k].size() >= 2)
                    smp = raw_hist[k][raw_hist[k].size() - 2];
                m_prs[k] = 1'b0;
                if (smp != m_lvl[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == DEB) begin
                        m_lvl[k] = smp;
                        m_run[k] = 0;
                        m_prs[k] = !smp;
                    end
                end else begin
                    m_run[k] = 0;
                end
                raw_hist[k].push_back(raw[k]);
                if (raw_hist[k].size() > 2)
                    void'(raw_hist[k].pop_front());
            end
        end
    end

    function automatic logic [18:0] dut_vec();
        return {entry_addr, entry_data, wr_req, busy, step_pulse};
    endfunction

    function automatic logic [18:0] mdl_vec();
        return {m_addr, m_data, m_wr, m_writing, m_prs[2] & ~entry_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (dut_vec() !== 19'h0)
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 19'h0);
        else
            passed++;
        total++;
        if (dut_vec() !== mdl_vec())
            $display("FAIL reset_model: got %h expected %h", dut_vec(), mdl_vec());
        else
            passed++;
    endtask

    task automatic test_bounce();
        int events = 0;
        logic [7:0] prev;
        entry_en = 1'b1;
        SW = 8'h3C;
        prev = entry_addr;
        for (int i = 0; i < 12; i++) begin
            KEY_addr = ((i / 2) % 2) != 0;
            tick();
            total++;
            if (dut_vec() !== mdl_vec())
                $display("FAIL bounce_cycle: got %h expected %h", dut_vec(), mdl_vec());
            else
                passed++;
            if (entry_addr !== prev) events++;
            prev = entry_addr;
        end
        KEY_addr = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (entry_addr !== prev) events++;
            prev = entry_addr;
            if (i == LAT - 1) begin
                total++;
                if (entry_addr !== 8'h00)
                    $display("FAIL bounce_early: got %h expected %h", entry_addr, 8'h00);
                else
                    passed++;
            end
        end
        total++;
        if (entry_addr !== 8'h3C)
            $display("FAIL bounce_addr: got %h expected %h", entry_addr, 8'h3C);
        else
            passed++;
        total++;
        if (events != 1)
            $display("FAIL bounce_events: got %0d expected %0d", events, 1);
        else
            passed++;
        KEY_addr = 1'b1;
        repeat (LAT) begin
            tick();
            total++;
            if (dut_vec() !== mdl_vec())
                $display("FAIL bounce_release: got %h expected %h", dut_vec(), mdl_vec());
            else
                passed++;
        end
    endtask

    task automatic test_write();
        SW = 8'hA5;
        KEY_data = 1'b0;
        repeat (LAT) tick();
        KEY_data = 1'b1;
        SW = 8'($urandom);
        total++;
        if ({wr_req, busy, entry_data, entry_addr} !== {2'b11, 8'hA5, 8'h3C})
            $display("FAIL write_start: got %h expected %h",
                     {wr_req, busy, entry_data, entry_addr}, {2'b11, 8'hA5, 8'h3C});
        else
            passed++;
        repeat (3) begin
            tick();
            total++;
            if (dut_vec() !== mdl_vec() || wr_req !== 1'b1)
                $display("FAIL write_hold: got %h expected %h", dut_vec(), mdl_vec());
            else
                passed++;
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        total++;
        if ({wr_req, busy, entry_addr} !== {2'b00, 8'h3D})
            $display("FAIL write_ack: got %h expected %h",
                     {wr_req, busy, entry_addr}, {2'b00, 8'h3D});
        else
            passed++;
        total++;
        if (!(m_armed && !m_writing))
            $display("FAIL write_armed: got %0d expected %0d", m_armed, 1);
        else
            passed++;
        repeat (LAT) tick();
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        SW = 8'hFF;
        KEY_addr = 1'b0;
        repeat (LAT) tick();
        KEY_addr = 1'b1;
        repeat (LAT) tick();
        d = 8'($urandom);
        SW = d;
        KEY_data = 1'b0;
        repeat (LAT) tick();
        KEY_data = 1'b1;
        repeat ($urandom_range(0, 4)) tick();
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        total++;
        if ({entry_addr, entry_data, wr_req} !== {8'h00, d, 1'b0})
            $display("FAIL wrap_addr: got %h expected %h",
                     {entry_addr, entry_data, wr_req}, {8'h00, d, 1'b0});
        else
            passed++;
        repeat (LAT) tick();
    endtask

    task automatic test_drops();
        int pulses;
        SW = 8'h5A;
        KEY_data = 1'b0;
        repeat (LAT) tick();
        KEY_data = 1'b1;
        SW = 8'h11;
        KEY_addr = 1'b0;
        repeat (LAT) tick();
        KEY_addr = 1'b1;
        repeat (LAT) tick();
        total++;
        if ({busy, entry_addr} !== {1'b1, 8'h00})
            $display("FAIL drop_in_write: got %h expected %h", {busy, entry_addr}, {1'b1, 8'h00});
        else
            passed++;
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        entry_en = 1'b0;
        tick();
        SW = 8'h77;
        KEY_addr = 1'b0;
        repeat (LAT) tick();
        KEY_addr = 1'b1;
        repeat (LAT) tick();
        total++;
        if ({busy, entry_addr} !== {1'b0, 8'h01} || dut_vec() !== mdl_vec())
            $display("FAIL drop_idle_addr: got %h expected %h", dut_vec(), mdl_vec());
        else
            passed++;
        entry_en = 1'b1;
        KEY_data = 1'b0;
        repeat (LAT) tick();
        KEY_data = 1'b1;
        repeat (LAT) tick();
        total++;
        if (wr_req !== 1'b0)
            $display("FAIL drop_idle_data: got %b expected %b", wr_req, 1'b0);
        else
            passed++;
        pulses = 0;
        KEY_step = 1'b0;
        repeat (LAT + 2) begin
            tick();
            if (step_pulse === 1'b1) pulses++;
        end
        KEY_step = 1'b1;
        repeat (LAT) tick();
        total++;
        if (pulses != 0)
            $display("FAIL step_entry: got %0d expected %0d", pulses, 0);
        else
            passed++;
        entry_en = 1'b0;
        KEY_step = 1'b0;
        repeat (LAT + 2) begin
            tick();
            if (step_pulse === 1'b1) pulses++;
            total++;
            if (dut_vec() !== mdl_vec())
                $display("FAIL step_cycle: got %h expected %h", dut_vec(), mdl_vec());
            else
                passed++;
        end
        KEY_step = 1'b1;
        repeat (LAT) begin
            tick();
            if (step_pulse === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1)
            $display("FAIL step_run: got %0d expected %0d", pulses, 1);
        else
            passed++;
    endtask

    task automatic test_clr();
        entry_en = 1'b1;
        SW = 8'h20;
        KEY_addr = 1'b0;
        repeat (LAT) tick();
        KEY_addr = 1'b1;
        repeat (LAT) tick();
        SW = 8'h99;
        KEY_data = 1'b0;
        repeat (LAT) tick();
        KEY_data = 1'b1;
        total++;
        if ({wr_req, entry_addr} !== {1'b1, 8'h20})
            $display("FAIL clr_setup: got %h expected %h", {wr_req, entry_addr}, {1'b1, 8'h20});
        else
            passed++;
        wr_ack = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wr_ack = 1'b0;
        total++;
        if ({wr_req, busy, entry_addr} !== {2'b00, 8'h00})
            $display("FAIL clr_mid: got %h expected %h", {wr_req, busy, entry_addr}, 10'h0);
        else
            passed++;
        repeat (LAT) tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) entry_en = ~entry_en;
            if ($urandom_range(0, 5) == 0) KEY_addr = ~KEY_addr;
            if ($urandom_range(0, 5) == 0) KEY_data = ~KEY_data;
            if ($urandom_range(0, 5) == 0) KEY_step = ~KEY_step;
            clr = ($urandom_range(0, 249) == 0);
            wr_ack = ($urandom_range(0, 2) == 0);
            SW = 8'($urandom);
            tick();
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle %0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end else begin
                passed++;
            end
        end
        clr = 1'b0;
        wr_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_write();
        test_wrap();
        test_drops();
        test_clr();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
